// File: rtl/realtank_ahb_decode_mux.sv
// RealTank AHB-Lite slave decode and response mux. Optional first-error address
// log is built in when REALTANK_DECODE_ERRLOG_EN is defined.
module realtank_ahb_decode_mux #(
  parameter int NSLV   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADY,
  output logic [NSLV-1:0]          HSEL_S,
  output logic                     HSEL_DEF,
  input  logic [NSLV-1:0]          HREADYOUT_S,
  input  logic [2*NSLV-1:0]        HRESP_S,
  input  logic [DATA_W*NSLV-1:0]   HRDATA_S,
  input  logic                     DEF_HREADYOUT,
  input  logic [1:0]               DEF_HRESP,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [DATA_W-1:0]        HRDATA,
  input  logic                     ERR_CLR,
  output logic                     ERR_VALID,
  output logic [ADDR_W-1:0]        ERR_ADDR
);

  localparam logic [NSLV:0] DSEL_DEF = {1'b1, {NSLV{1'b0}}};
  localparam logic [1:0]    RESP_ERROR = 2'b01;

  logic [NSLV-1:0] hsel_s;
  logic            hsel_def;
  logic            found;

  logic [NSLV:0]   dsel_q, dsel_d;

  logic            hreadyout_mux;
  logic [1:0]      hresp_mux;
  logic [DATA_W-1:0] hrdata_mux;

  // Address decode: first matching region (lowest index) wins.
  always_comb begin
    hsel_s = '0;
    found  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!found &&
          ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hsel_s[i] = 1'b1;
        found     = 1'b1;
      end
    end
    hsel_def = !found;
  end

  assign HSEL_S   = hsel_s;
  assign HSEL_DEF = hsel_def;

  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      dsel_d = {hsel_def, hsel_s};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= DSEL_DEF;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // dsel is one-hot, so an AND-OR mux suffices; the default slave has no read data.
  always_comb begin
    hreadyout_mux = 1'b0;
    hresp_mux     = 2'b00;
    hrdata_mux    = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q[i]) begin
        hreadyout_mux = hreadyout_mux | HREADYOUT_S[i];
        hresp_mux     = hresp_mux | HRESP_S[2*i +: 2];
        hrdata_mux    = hrdata_mux | HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
    if (dsel_q[NSLV]) begin
      hreadyout_mux = hreadyout_mux | DEF_HREADYOUT;
      hresp_mux     = hresp_mux | DEF_HRESP;
    end
  end

  assign HREADYOUT = hreadyout_mux;
  assign HRESP     = hresp_mux;
  assign HRDATA    = hrdata_mux;

`ifdef REALTANK_DECODE_ERRLOG_EN
  logic [ADDR_W-1:0] dphase_addr_q, dphase_addr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_valid_q, err_valid_d;
  logic              err_det;
  logic              unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Only the first cycle of the two-cycle ERROR response counts as a detect.
  assign err_det = (hresp_mux == RESP_ERROR) && !hreadyout_mux;

  always_comb begin
    dphase_addr_d = dphase_addr_q;
    err_addr_d    = err_addr_q;
    err_valid_d   = err_valid_q;
    if (HREADY && HTRANS[1]) begin
      dphase_addr_d = HADDR;
    end
    if (err_det && (!err_valid_q || ERR_CLR)) begin
      err_valid_d = 1'b1;
      err_addr_d  = dphase_addr_q;
    end else if (ERR_CLR) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_addr_q <= '0;
      err_addr_q    <= '0;
      err_valid_q   <= 1'b0;
    end else begin
      dphase_addr_q <= dphase_addr_d;
      err_addr_q    <= err_addr_d;
      err_valid_q   <= err_valid_d;
    end
  end

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;
`else
  logic unused_errlog;

  assign unused_errlog = ^{HTRANS, ERR_CLR, RESP_ERROR};
  assign ERR_VALID     = 1'b0;
  assign ERR_ADDR      = '0;
`endif

endmodule

// File: tb/tb_realtank_ahb_decode_mux.sv
// Bench for realtank_ahb_decode_mux: directed cases pinned with literal values,
// then randomized traffic checked every cycle against an index-level model.
module tb_realtank_ahb_decode_mux;

  localparam int NSLV = 4;
`ifdef REALTANK_DECODE_ERRLOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  // Region 3 (xxxx_1xxx) overlaps region 0 for 0x0000_1xxx; region 0 must win there.
  localparam logic [127:0] BASES = {32'h0000_1000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [127:0] MASKS = {32'h0000_F000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic         hclk = 1'b0;
  logic         hreset;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hready;
  logic [3:0]   hsel_s;
  logic         hsel_def;
  logic [3:0]   hreadyout_s;
  logic [7:0]   hresp_s;
  logic [127:0] hrdata_s;
  logic         def_hreadyout;
  logic [1:0]   def_hresp;
  logic         hreadyout;
  logic [1:0]   hresp;
  logic [31:0]  hrdata;
  logic         err_clr;
  logic         err_valid;
  logic [31:0]  err_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  realtank_ahb_decode_mux #(
    .NSLV(NSLV), .ADDR_W(32), .DATA_W(32), .SLV_BASE(BASES), .SLV_MASK(MASKS)
  ) dut (
    .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HREADY(hready),
    .HSEL_S(hsel_s), .HSEL_DEF(hsel_def), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
    .HRDATA_S(hrdata_s), .DEF_HREADYOUT(def_hreadyout), .DEF_HRESP(def_hresp),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .ERR_CLR(err_clr),
    .ERR_VALID(err_valid), .ERR_ADDR(err_addr)
  );

  always #5 hclk = ~hclk;

  // ---------------- reference model ----------------
  logic [31:0] base_a [NSLV];
  logic [31:0] mask_a [NSLV];
  initial begin
    for (int i = 0; i < NSLV; i++) begin
      base_a[i] = BASES[i*32 +: 32];
      mask_a[i] = MASKS[i*32 +: 32];
    end
  end

  int          m_dsl = NSLV;  // slave index owning the data phase; NSLV = default slave
  logic [31:0] m_dpa = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_eaddr = '0;

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return NSLV;
  endfunction

  function automatic logic exp_ready();
    return (m_dsl == NSLV) ? def_hreadyout : hreadyout_s[m_dsl];
  endfunction

  function automatic logic [1:0] exp_resp();
    return (m_dsl == NSLV) ? def_hresp : hresp_s[m_dsl*2 +: 2];
  endfunction

  function automatic logic [31:0] exp_rdata();
    return (m_dsl == NSLV) ? 32'h0 : hrdata_s[m_dsl*32 +: 32];
  endfunction

  always @(posedge hclk) begin
    if (hreset) begin
      m_dsl   <= NSLV;
      m_dpa   <= '0;
      m_valid <= 1'b0;
      m_eaddr <= '0;
    end else begin
      if (hready) m_dsl <= dec(haddr);
      if (hready && htrans[1]) m_dpa <= haddr;
      if (LOG_EN) begin
        if (exp_resp() == 2'b01 && !exp_ready() && (!m_valid || err_clr)) begin
          m_valid <= 1'b1;
          m_eaddr <= m_dpa;
        end else if (err_clr) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model; inputs are stable at the falling edge.
  always @(negedge hclk) begin
    if (chk_en) begin : cmp
      int d;
      d = dec(haddr);
      check("hsel_s",    {60'h0, hsel_s}, (d < NSLV) ? (64'h1 << d) : 64'h0);
      check("hsel_def",  {63'h0, hsel_def}, {63'h0, (d == NSLV)});
      check("hreadyout", {63'h0, hreadyout}, {63'h0, exp_ready()});
      check("hresp",     {62'h0, hresp}, {62'h0, exp_resp()});
      check("hrdata",    {32'h0, hrdata}, {32'h0, exp_rdata()});
      check("err_valid", {63'h0, err_valid}, {63'h0, m_valid});
      check("err_addr",  {32'h0, err_addr}, {32'h0, m_eaddr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge hclk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge hclk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {4'h0, r[27:0]};
      1: return {4'h2, r[27:0]};
      2: return {4'h4, r[27:0]};
      3: return {4'h8, r[27:16], 4'h1, r[11:0]};
      4: return {20'h00001, r[11:0]};
      5: return {4'h3, r[27:0]};
      default: return r;
    endcase
  endfunction

  task automatic rnd_inputs();
    hreset        = ($urandom_range(0, 99) == 0);
    haddr         = rnd_addr();
    htrans        = 2'($urandom_range(0, 3));
    hready        = ($urandom_range(0, 4) != 0);
    for (int i = 0; i < NSLV; i++) begin
      hreadyout_s[i]     = ($urandom_range(0, 3) != 0);
      hresp_s[2*i +: 2]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hrdata_s[i*32 +: 32] = $urandom;
    end
    def_hreadyout = ($urandom_range(0, 3) != 0);
    def_hresp     = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b00;
    err_clr       = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    hreset = 1'b1; haddr = 32'h0; htrans = 2'b00; hready = 1'b1;
    hreadyout_s = 4'hF; hresp_s = '0; hrdata_s = '0;
    def_hreadyout = 1'b1; def_hresp = 2'b00; err_clr = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    hreset = 1'b0; haddr = 32'hFFFF_0000;
    at_neg();
    check("lit_idle_def",   {63'h0, hsel_def}, 64'h1);
    check("lit_idle_ready", {63'h0, hreadyout}, 64'h1);
    check("lit_idle_resp",  {62'h0, hresp}, 64'h0);
    check("lit_idle_rdata", {32'h0, hrdata}, 64'h0);

    cyc();
    haddr = 32'h2000_0010; htrans = 2'b10;
    at_neg();
    check("lit_sel_s1", {60'h0, hsel_s}, 64'h2);
    cyc();
    haddr = 32'hFFFF_0000; htrans = 2'b00; hrdata_s[63:32] = 32'hA5A5_5A5A;
    at_neg();
    check("lit_s1_rdata", {32'h0, hrdata}, 64'hA5A5_5A5A);

    cyc();
    haddr = 32'h4000_0000; htrans = 2'b10;
    cyc();
    hreadyout_s[2] = 1'b0; hready = 1'b0; haddr = 32'h0000_0004;
    hrdata_s[31:0] = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("lit_wait_ready", {63'h0, hreadyout}, 64'h0);
      cyc();
    end
    hreadyout_s[2] = 1'b1; hready = 1'b1;
    at_neg();
    check("lit_wait_release", {63'h0, hreadyout}, 64'h1);
    check("lit_sel_s0", {60'h0, hsel_s}, 64'h1);
    cyc();
    haddr = 32'hFFFF_0000; htrans = 2'b00;
    at_neg();
    check("lit_s0_rdata", {32'h0, hrdata}, 64'h1234_5678);

    cyc();
    haddr = 32'h0000_1000;
    at_neg();
    check("lit_overlap", {60'h0, hsel_s}, 64'h1);
    cyc();
    haddr = 32'h5000_1000;
    at_neg();
    check("lit_region3", {60'h0, hsel_s}, 64'h8);

    // First error at 0x3000_0000, then a second one that must not overwrite it.
    for (int e = 0; e < 2; e++) begin
      cyc();
      haddr = (e == 0) ? 32'h3000_0000 : 32'h3100_0000; htrans = 2'b10; hready = 1'b1;
      cyc();
      def_hresp = 2'b01; def_hreadyout = 1'b0; hready = 1'b0; htrans = 2'b00;
      haddr = 32'hFFFF_0000;
      cyc();
      def_hreadyout = 1'b1; hready = 1'b1;
      at_neg();
      check("lit_err_valid", {63'h0, err_valid}, {63'h0, LOG_EN});
      check("lit_err_addr",  {32'h0, err_addr}, LOG_EN ? 64'h3000_0000 : 64'h0);
      cyc();
      def_hresp = 2'b00;
    end

    haddr = 32'h3200_0000; htrans = 2'b10;
    cyc();
    def_hresp = 2'b01; def_hreadyout = 1'b0; hready = 1'b0; htrans = 2'b00;
    haddr = 32'hFFFF_0000; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; def_hreadyout = 1'b1; hready = 1'b1;
    at_neg();
    check("lit_clr_race_valid", {63'h0, err_valid}, {63'h0, LOG_EN});
    check("lit_clr_race_addr",  {32'h0, err_addr}, LOG_EN ? 64'h3200_0000 : 64'h0);
    cyc();
    def_hresp = 2'b00; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    at_neg();
    check("lit_clr_valid", {63'h0, err_valid}, 64'h0);

    // Reset in the middle of a slave-1 data phase.
    cyc();
    haddr = 32'h2000_0000; htrans = 2'b10; hrdata_s[63:32] = 32'hDEAD_BEEF;
    cyc();
    hreset = 1'b1;
    cyc();
    hreset = 1'b0; haddr = 32'hFFFF_0000; htrans = 2'b00;
    at_neg();
    check("lit_rst_rdata", {32'h0, hrdata}, 64'h0);
    check("lit_rst_ready", {63'h0, hreadyout}, 64'h1);

    for (int n = 0; n < 3000; n++) begin
      cyc();
      rnd_inputs();
    end
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
